display_scan_controller: RTL and testbench

Time-multiplexed scan controller for the timer's four-digit seven-segment display. It holds the value to show and drives one shared display decoder, presenting one 4-bit glyph code at a time. It walks the digit anodes with a dead-time blank between digits, and applies leading-zero suppression. It also forces a blinking "Erro" word on error or on an invalid BCD load. The block sits between the timer core, which supplies the BCD value and the error flag, and the decoder plus the anode drivers.

---
 rtl/display_scan_controller.sv | 203 ++++++++++++++++++++
 tb/tb_display_scan_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_controller.sv
// display_scan_controller
//
// Time-multiplexed scan controller for a four-digit seven-segment display.
// Holds a BCD value behind a shadow register, walks the anodes 3..0 with a
// dead-time blank at the start of each digit slot, applies optional
// leading-zero suppression, and substitutes a blinking "Erro" word when the
// error input is high or the displayed value contains a non-BCD nibble.
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - asynchronous active-low reset
//   enable     - scanning runs while high
//   load       - one-cycle strobe that captures value into the shadow
//   value      - four BCD nibbles, [15:12] is digit 3 (leftmost)
//   error      - level request for the error word
//   zero_blank - enables leading-zero suppression
//   code       - registered glyph code for the shared decoder
//   digit_n    - registered active-low anode selects
//   frame_done - one-cycle pulse in the last cycle of digit 0's slot

module display_scan_controller #(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned BLINK_FRAMES = 32,
    parameter logic [3:0]  ERR_E        = 4'b1100,
    parameter logic [3:0]  ERR_R        = 4'b1110,
    parameter logic [3:0]  ERR_O        = 4'b1111
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        error,
    input  logic        zero_blank,
    output logic [3:0]  code,
    output logic [3:0]  digit_n,
    output logic        frame_done
);

    localparam int unsigned CW = $clog2(SCAN_DIV);
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CW-1:0] SlotLast  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BlankLast = CW'(BLANK_CYCLES - 1);
    localparam logic [FW-1:0] FrameLast = FW'(BLINK_FRAMES - 1);

    typedef enum logic [1:0] {StIdle, StBlank, StOn} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic [15:0]   disp_q, disp_d;
    logic          bad_q, bad_d;
    logic          err_mode_q, err_mode_d;
    logic          blink_on_q, blink_on_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic [3:0]    code_d, digit_n_d;
    logic          frame_done_d;

    logic          boundary;
    logic [3:0]    glyph;
    logic          lead_zero;

    function automatic logic has_bad_nibble(input logic [15:0] v);
        has_bad_nibble = (v[15:12] > 4'd9) || (v[11:8] > 4'd9) ||
                         (v[7:4] > 4'd9) || (v[3:0] > 4'd9);
    endfunction

    // Shadow, display register, bad-value flag and error/blink mode.
    // Everything except the shadow only moves at a frame boundary.
    always_comb begin
        boundary   = enable && (state_q != StIdle) && (cnt_q == SlotLast) && (idx_q == 2'd0);
        shadow_d   = load ? value : shadow_q;
        pending_d  = pending_q | load;
        disp_d     = disp_q;
        bad_d      = bad_q;
        err_mode_d = err_mode_q;
        blink_on_d = blink_on_q;
        fcnt_d     = fcnt_q;
        if (boundary) begin
            pending_d = 1'b0;
            if (load || pending_q) begin
                // A load on the boundary cycle bypasses the shadow.
                disp_d = load ? value : shadow_q;
                bad_d  = has_bad_nibble(disp_d);
            end
            err_mode_d = error | bad_d;
            if (err_mode_d && !err_mode_q) begin
                blink_on_d = 1'b1;
                fcnt_d     = '0;
            end else if (err_mode_d) begin
                if (fcnt_q == FrameLast) begin
                    fcnt_d     = '0;
                    blink_on_d = ~blink_on_q;
                end else begin
                    fcnt_d = fcnt_q + FW'(1);
                end
            end
        end
    end

    // Scan sequencing: slot counter, digit index and blank/on phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        if (!enable) begin
            state_d = StIdle;
            cnt_d   = '0;
            idx_d   = 2'd3;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StBlank;
                    cnt_d   = '0;
                    idx_d   = 2'd3;
                end
                StBlank, StOn: begin
                    if (cnt_q == SlotLast) begin
                        state_d = StBlank;
                        cnt_d   = '0;
                        idx_d   = idx_q - 2'd1;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = (cnt_q == BlankLast) ? StOn : state_q;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                    idx_d   = 2'd3;
                end
            endcase
        end
    end

    // Output values for the upcoming cycle, derived from next-state so the
    // first BLANK after a boundary already shows the newly copied value.
    always_comb begin
        if (err_mode_d) begin
            case (idx_d)
                2'd3:    glyph = ERR_E;
                2'd0:    glyph = ERR_O;
                default: glyph = ERR_R;
            endcase
        end else begin
            glyph = disp_d[{idx_d, 2'b00} +: 4];
        end

        case (idx_d)
            2'd3:    lead_zero = (disp_d[15:12] == 4'h0);
            2'd2:    lead_zero = (disp_d[15:8] == 8'h00);
            2'd1:    lead_zero = (disp_d[15:4] == 12'h000);
            default: lead_zero = 1'b0;
        endcase

        digit_n_d = 4'b1111;
        if (state_d == StOn) begin
            if (err_mode_d ? blink_on_d : !(zero_blank && lead_zero)) begin
                digit_n_d = ~(4'b0001 << idx_d);
            end
        end

        code_d       = (state_d == StIdle) ? code : glyph;
        frame_done_d = (state_d != StIdle) && (cnt_d == SlotLast) && (idx_d == 2'd0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= 2'd3;
            shadow_q   <= 16'h0000;
            pending_q  <= 1'b0;
            disp_q     <= 16'h0000;
            bad_q      <= 1'b0;
            err_mode_q <= 1'b0;
            blink_on_q <= 1'b1;
            fcnt_q     <= '0;
            code       <= 4'h0;
            digit_n    <= 4'b1111;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            disp_q     <= disp_d;
            bad_q      <= bad_d;
            err_mode_q <= err_mode_d;
            blink_on_q <= blink_on_d;
            fcnt_q     <= fcnt_d;
            code       <= code_d;
            digit_n    <= digit_n_d;
            frame_done <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
module tb_display_scan_controller;

    localparam int SD     = 8;
    localparam int BC     = 2;
    localparam int BF     = 2;
    localparam int FP     = 4 * SD;
    localparam int FRAMES = 40;

    typedef struct packed {
        logic [15:0] codes;  // expected glyph per digit, digit k at [4k+:4]
        logic [3:0]  lit;    // expected anode lit during ON, per digit
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0000;
    logic        error = 1'b0;
    logic        zero_blank = 1'b0;
    logic [3:0]  code;
    logic [3:0]  digit_n;
    logic        frame_done;

    int checks = 0;
    int failures = 0;

    frame_t exp_q[$];
    bit     mon_on = 1'b0;
    int     mpos = 0;
    int     lit_cnt[4];
    logic [3:0] bcode[4];
    logic [3:0] ocode[4];
    int     stray = 0;

    // Reference model state
    logic [15:0] m_disp = 16'h0000;
    logic [15:0] m_new = 16'h0000;
    bit          m_have = 1'b0;
    bit          m_bad = 1'b0;
    bit          m_err = 1'b0;
    int          m_kerr = 0;
    logic [15:0] errw = 16'hCEEF;  // E r r o, digit 3 first

    always #5 clk = ~clk;

    display_scan_controller #(
        .SCAN_DIV    (SD),
        .BLANK_CYCLES(BC),
        .BLINK_FRAMES(BF),
        .ERR_E       (4'b1100),
        .ERR_R       (4'b1110),
        .ERR_O       (4'b1111)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .load      (load),
        .value     (value),
        .error     (error),
        .zero_blank(zero_blank),
        .code      (code),
        .digit_n   (digit_n),
        .frame_done(frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic frame_t expect_frame();
        frame_t e;
        for (int k = 0; k < 4; k++) begin
            if (m_err) begin
                e.codes[4*k +: 4] = errw[4*k +: 4];
                e.lit[k] = ((m_kerr / BF) % 2) == 0;
            end else begin
                e.codes[4*k +: 4] = m_disp[4*k +: 4];
                e.lit[k] = !(zero_blank && k != 0 && (m_disp >> (4 * k)) == 16'h0);
            end
        end
        return e;
    endfunction

    function automatic logic [15:0] rand_value();
        logic [15:0] r;
        for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
        case ($urandom_range(0, 4))
            0: r = 16'($urandom);
            1: r = r & 16'h00FF;
            2: r = r & 16'h000F;
            default: ;
        endcase
        return r;
    endfunction

    // Monitor: collects one frame of anode/code activity, then scores it.
    always @(negedge clk) begin : monitor
        frame_t e;
        int k;
        int off;
        if (mon_on) begin
            k   = 3 - mpos / SD;
            off = mpos % SD;
            if (off == 1) bcode[k] = code;
            if (off == SD - 1) ocode[k] = code;
            if (digit_n != 4'b1111) begin
                if (digit_n == ~(4'b0001 << k) && off >= BC) lit_cnt[k]++;
                else stray++;
            end
            if (frame_done || mpos == FP - 1) begin
                check("frame_done_at_pos31", frame_done ? mpos : 99, FP - 1);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL scoreboard_empty: got 0 entries, expected 1");
                end else begin
                    e = exp_q.pop_front();
                    for (int d = 0; d < 4; d++) begin
                        check($sformatf("lit_cycles_d%0d", d), lit_cnt[d],
                              e.lit[d] ? SD - BC : 0);
                        check($sformatf("blank_code_d%0d", d), bcode[d], e.codes[4*d +: 4]);
                        check($sformatf("on_code_d%0d", d), ocode[d], e.codes[4*d +: 4]);
                    end
                    check("stray_anodes", stray, 0);
                end
                for (int d = 0; d < 4; d++) begin
                    lit_cnt[d] = 0;
                    bcode[d]   = 4'hx;
                    ocode[d]   = 4'hx;
                end
                stray = 0;
                mpos  = 0;
            end else begin
                mpos++;
            end
        end
    end

    // Stimulus plus reference model updates at each frame boundary.
    initial begin : stimulus
        logic [15:0] v;
        bit ld;
        bit new_err;
        for (int d = 0; d < 4; d++) lit_cnt[d] = 0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_code", code, 4'h0);
        check("reset_digit_n", digit_n, 4'b1111);
        check("reset_frame_done", frame_done, 1'b0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_digit_n", digit_n, 4'b1111);

        exp_q.push_back(expect_frame());
        enable = 1'b1;
        @(posedge clk);
        mon_on = 1'b1;

        for (int f = 0; f < FRAMES; f++) begin
            for (int p = 0; p < FP; p++) begin
                @(negedge clk);
                ld = 1'b0;
                v  = 16'h0000;
                if (f < 12) begin
                    if (p == 5) begin
                        case (f)
                            0:  begin ld = 1'b1; v = 16'h1234; end
                            1:  begin ld = 1'b1; v = 16'h0050; end
                            2:  begin ld = 1'b1; v = 16'h0000; end
                            3:  begin ld = 1'b1; v = 16'h12A4; end
                            7:  begin ld = 1'b1; v = 16'h0009; end
                            11: begin ld = 1'b1; v = 16'h2222; end
                            default: ;
                        endcase
                    end
                    if (f == 10 && p == FP - 1) begin ld = 1'b1; v = 16'h1111; end
                    if (f == 11 && p == 20) begin ld = 1'b1; v = 16'h3456; end
                    if (f == 8 && p == 13) error = 1'b1;
                    if (f == 9 && p == 13) error = 1'b0;
                end else if (f < FRAMES - 1) begin
                    if ($urandom_range(0, 15) == 0) begin
                        ld = 1'b1;
                        v  = rand_value();
                    end
                    if ($urandom_range(0, 63) == 0) error = ~error;
                end else begin
                    error = 1'b0;
                    if (p == 3) begin ld = 1'b1; v = 16'h5678; end
                end
                load  = ld;
                value = ld ? v : 16'($urandom);
                if (ld) begin
                    m_new  = v;
                    m_have = 1'b1;
                end
                if (p == FP - 1) begin
                    if (f == 1) zero_blank = 1'b1;
                    else if (f == FRAMES - 1) zero_blank = 1'b0;
                    else if (f >= 12 && $urandom_range(0, 3) == 0) zero_blank = ~zero_blank;
                    if (m_have) begin
                        m_disp = m_new;
                        m_have = 1'b0;
                        m_bad  = 1'b0;
                        for (int k = 0; k < 4; k++) if (m_disp[4*k +: 4] > 4'd9) m_bad = 1'b1;
                    end
                    new_err = error | m_bad;
                    if (new_err) m_kerr = m_err ? m_kerr + 1 : 0;
                    m_err = new_err;
                    exp_q.push_back(expect_frame());
                end
            end
        end

        @(posedge clk);
        mon_on = 1'b0;
        load   = 1'b0;
        exp_q.delete();

        // Frame now showing 5678, all lit: drop enable during digit 1 ON.
        repeat (20) @(negedge clk);
        check("d1_on_digit_n", digit_n, 4'b1101);
        check("d1_on_code", code, 4'h7);
        enable = 1'b0;
        @(negedge clk);
        check("disable_digit_n", digit_n, 4'b1111);
        repeat (2) @(negedge clk);
        check("idle_hold_digit_n", digit_n, 4'b1111);
        enable = 1'b1;
        @(negedge clk);
        check("reenable_blank_digit_n", digit_n, 4'b1111);
        check("reenable_blank_code", code, 4'h5);
        @(negedge clk);
        check("reenable_blank2_digit_n", digit_n, 4'b1111);
        @(negedge clk);
        check("reenable_on_digit_n", digit_n, 4'b0111);
        check("reenable_on_code", code, 4'h5);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_code", code, 4'h0);
        check("async_reset_digit_n", digit_n, 4'b1111);
        check("async_reset_frame_done", frame_done, 1'b0);
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
